// File: rtl/aes_cbc_ctrl.sv
// aes_cbc_ctrl: CBC/ECB block-chaining controller sitting directly upstream of aes_core_gen.
// Define AES_CBC_WDOG_EN to add a core_done watchdog and the sticky wdog_err output.
module aes_cbc_ctrl #(
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_enc_dec,
  input  logic [1:0]   cfg_mode,
  input  logic         cfg_cbc,
  input  logic         iv_load,
  input  logic [127:0] iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         core_start,
  output logic         core_enc_dec,
  output logic [1:0]   core_mode,
  output logic [127:0] core_data_in,
  input  logic [127:0] core_data_out,
  input  logic         core_done
`ifdef AES_CBC_WDOG_EN
  ,
  output logic         wdog_err
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  if (WDOG_CYCLES == 0) begin : g_cfg_check
    $error("aes_cbc_ctrl: WDOG_CYCLES must be at least 1");
  end

  logic [1:0]   state;
  logic [127:0] chain;
  logic [127:0] blk;
  logic [127:0] chain_eff;
  logic         cbc_q;

`ifdef AES_CBC_WDOG_EN
  localparam int unsigned       WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_cnt;
`endif

  // A same-cycle iv_load takes effect for the block accepted in that cycle.
  always_comb begin
    chain_eff = iv_load ? iv : chain;
  end

  assign in_ready   = reset && (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign core_start = (state == S_LAUNCH);
  assign out_valid  = (state == S_OUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      chain        <= '0;
      blk          <= '0;
      cbc_q        <= 1'b0;
      core_enc_dec <= 1'b0;
      core_mode    <= '0;
      core_data_in <= '0;
      out_data     <= '0;
`ifdef AES_CBC_WDOG_EN
      wdog_cnt     <= '0;
      wdog_err     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (iv_load) begin
            chain <= iv;
`ifdef AES_CBC_WDOG_EN
            wdog_err <= 1'b0;
`endif
          end
          if (in_valid) begin
            cbc_q        <= cfg_cbc;
            core_enc_dec <= cfg_enc_dec;
            core_mode    <= cfg_mode;
            blk          <= in_data;
            core_data_in <= (cfg_cbc && !cfg_enc_dec) ? (in_data ^ chain_eff) : in_data;
            state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
`ifdef AES_CBC_WDOG_EN
          wdog_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            out_data <= (cbc_q && core_enc_dec) ? (core_data_out ^ chain) : core_data_out;
            if (cbc_q) begin
              chain <= core_enc_dec ? blk : core_data_out;
            end
            state <= S_OUT;
          end
`ifdef AES_CBC_WDOG_EN
          // Timeout fires on the WDOG_CYCLES-th WAIT cycle; a coincident done wins above.
          else if (wdog_cnt == WDOG_LAST) begin
            wdog_err <= 1'b1;
            state    <= S_IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
          end
`endif
        end
        S_OUT: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
